instruction_fetch_stage: RTL and testbench

Front end of the MIPS pipeline. Owns the program counter, drives the fetch address into the asynchronous program ROM, and registers the returned instruction and PC+4 into the IF/ID pipeline register. Selects the next PC from sequential, branch, jump, and jump-register sources, resolved in ID. Stops fetching permanently when the PC leaves the program image.

---
 rtl/instruction_fetch_stage.sv | 181 ++++++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// -----------------------------------------------------------------------------
// instruction_fetch_stage
//
// Front end of the MIPS pipeline. Owns the program counter, presents it to the
// asynchronous program ROM, and captures the returned instruction together with
// PC+4 into the IF/ID pipeline register. The next PC is chosen from the
// sequential path or from a redirect (JR/JALR, J/JAL, taken branch) resolved in
// ID. Fetch stops permanently once the PC leaves the program image.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   Stall             hold PC and IF/ID (load-use hazard from ID)
//   BranchTaken       conditional branch resolved taken, target BranchTarget
//   Jump              J/JAL in ID, target built from JumpIndex
//   JumpReg           JR/JALR in ID, target JumpRegTarget
//   Instruction       ROM read data for PC (combinational)
//   PC                current fetch address (register output)
//   IFID_Instruction  registered instruction
//   IFID_PCPlus4      registered PC+4 of that instruction
//   IFID_Valid        IF/ID holds a real instruction
//   Halted            fetch stopped on an illegal PC
//   FetchCount        instructions accepted into IF/ID (wraps)
// -----------------------------------------------------------------------------
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0040_0000,
    parameter int unsigned MEMORY_DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegTarget,
    input  logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic        Halted,
    output logic [31:0] FetchCount
);

    localparam int unsigned XLEN    = 32;
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] MEM_WORDS = XLEN'(MEMORY_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   ifid_instr_q, ifid_instr_d;
    logic [XLEN-1:0]   ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic              halted_q, halted_d;
    logic [XLEN-1:0]   fetch_count_q, fetch_count_d;

    logic              redirect;
    logic [XLEN-1:0]   redirect_target;
    logic [XLEN-1:0]   jump_target;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   pc_offset;
    logic              pc_legal;

    // Redirect target selection: JR beats J beats taken branch.
    always_comb begin
        jump_target = {ifid_pc_plus4_q[31:28], JumpIndex, 2'b00};
        redirect    = JumpReg | Jump | BranchTaken;
        if (JumpReg) begin
            redirect_target = JumpRegTarget;
        end else if (Jump) begin
            redirect_target = jump_target;
        end else begin
            redirect_target = BranchTarget;
        end
    end

    // PC legality against the program image; offset is only meaningful when
    // pc_q >= RESET_PC, which the same expression also requires.
    always_comb begin
        pc_plus4  = pc_q + PC_STEP;
        pc_offset = pc_q - RESET_PC;
        pc_legal  = (pc_q[1:0] == 2'b00)
                 && (pc_q >= RESET_PC)
                 && ((pc_offset >> 2) < MEM_WORDS);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: halt only on a quiet edge with an out-of-image PC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (!redirect && !Stall && !pc_legal) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Datapath next values per state; everything holds unless updated.
    always_comb begin
        pc_d            = pc_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_valid_d    = ifid_valid_q;
        halted_d        = halted_q;
        fetch_count_d   = fetch_count_q;
        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    // Redirect wins over Stall and legality; the wrong-path
                    // fetch becomes a bubble.
                    pc_d            = redirect_target;
                    ifid_instr_d    = '0;
                    ifid_pc_plus4_d = '0;
                    ifid_valid_d    = 1'b0;
                end else if (Stall) begin
                    pc_d = pc_q;
                end else if (pc_legal) begin
                    pc_d            = pc_plus4;
                    ifid_instr_d    = Instruction;
                    ifid_pc_plus4_d = pc_plus4;
                    ifid_valid_d    = 1'b1;
                    fetch_count_d   = fetch_count_q + XLEN'(1);
                end else begin
                    ifid_instr_d    = '0;
                    ifid_pc_plus4_d = '0;
                    ifid_valid_d    = 1'b0;
                    halted_d        = 1'b1;
                end
            end
            ST_HALT: begin
                halted_d = 1'b1;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q            <= RESET_PC;
            ifid_instr_q    <= '0;
            ifid_pc_plus4_q <= '0;
            ifid_valid_q    <= 1'b0;
            halted_q        <= 1'b0;
            fetch_count_q   <= '0;
        end else begin
            pc_q            <= pc_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_valid_q    <= ifid_valid_d;
            halted_q        <= halted_d;
            fetch_count_q   <= fetch_count_d;
        end
    end

    assign PC               = pc_q;
    assign IFID_Instruction = ifid_instr_q;
    assign IFID_PCPlus4     = ifid_pc_plus4_q;
    assign IFID_Valid       = ifid_valid_q;
    assign Halted           = halted_q;
    assign FetchCount       = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_stage
//
// Bench for instruction_fetch_stage. A behavioural ROM returns word k =
// 0x1000_0000 + k inside the image. Expected IF/ID contents are queued when a
// fetch is driven and popped after the edge that should capture it.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_stage;

    localparam logic [31:0] RESET_PC     = 32'h0040_0000;
    localparam int unsigned MEMORY_DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [25:0] JumpIndex;
    logic        JumpReg;
    logic [31:0] JumpRegTarget;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic        Halted;
    logic [31:0] FetchCount;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_stage #(
        .RESET_PC     (RESET_PC),
        .MEMORY_DEPTH (MEMORY_DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .Stall            (Stall),
        .BranchTaken      (BranchTaken),
        .BranchTarget     (BranchTarget),
        .Jump             (Jump),
        .JumpIndex        (JumpIndex),
        .JumpReg          (JumpReg),
        .JumpRegTarget    (JumpRegTarget),
        .Instruction      (Instruction),
        .PC               (PC),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid),
        .Halted           (Halted),
        .FetchCount       (FetchCount)
    );

    // Program ROM: word k inside the image, a marker value outside it.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - RESET_PC;
        if (a[1:0] == 2'b00 && a >= RESET_PC && (off >> 2) < MEMORY_DEPTH)
            return 32'h1000_0000 + (off >> 2);
        return 32'hDEAD_BEEF;
    endfunction

    always_comb Instruction = rom_word(PC);

    task automatic idle_inputs();
        Stall         = 1'b0;
        BranchTaken   = 1'b0;
        BranchTarget  = 32'h0;
        Jump          = 1'b0;
        JumpIndex     = 26'h0;
        JumpReg       = 1'b0;
        JumpRegTarget = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [31:0] addr);
        exp_t e;
        e.instr = rom_word(addr);
        e.pc4   = addr + 32'd4;
        sb_q.push_back(e);
    endtask

    function automatic void sb_pop(output exp_t e, output bit ok);
        ok = (sb_q.size() != 0);
        e  = '0;
        if (ok) e = sb_q.pop_front();
    endfunction

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #3;
        checks++;
        if (PC !== RESET_PC) begin
            errors++; $display("FAIL reset_pc: got %h want %h", PC, RESET_PC);
        end
        checks++;
        if (IFID_Instruction !== 32'h0 || IFID_PCPlus4 !== 32'h0 || IFID_Valid !== 1'b0) begin
            errors++; $display("FAIL reset_ifid: got %h/%h/%b want 0/0/0",
                               IFID_Instruction, IFID_PCPlus4, IFID_Valid);
        end
        checks++;
        if (Halted !== 1'b0 || FetchCount !== 32'h0) begin
            errors++; $display("FAIL reset_status: halted %b count %0d want 0/0", Halted, FetchCount);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        exp_t e; bit ok;
        for (int k = 0; k < 4; k++) begin
            push_fetch(RESET_PC + 32'(4 * k));
            tick();
            sb_pop(e, ok);
            checks++;
            if (!ok || IFID_Instruction !== e.instr || IFID_PCPlus4 !== e.pc4 || IFID_Valid !== 1'b1) begin
                errors++; $display("FAIL seq_fetch%0d: got %h/%h/%b want %h/%h/1",
                                   k, IFID_Instruction, IFID_PCPlus4, IFID_Valid, e.instr, e.pc4);
            end
        end
        checks++;
        if (FetchCount !== 32'd4 || PC !== 32'h0040_0010) begin
            errors++; $display("FAIL seq_count: count %0d pc %h want 4/00400010", FetchCount, PC);
        end
    endtask

    task automatic test_stall();
        exp_t e; bit ok;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            push_fetch(RESET_PC + 32'(4 * k));
            tick();
            sb_pop(e, ok);
            checks++;
            if (!ok || IFID_Instruction !== e.instr || IFID_PCPlus4 !== e.pc4 || IFID_Valid !== 1'b1) begin
                errors++; $display("FAIL stall_pre%0d: got %h/%h want %h/%h",
                                   k, IFID_Instruction, IFID_PCPlus4, e.instr, e.pc4);
            end
        end
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (PC !== 32'h0040_0008 || IFID_Instruction !== 32'h1000_0001 ||
                IFID_PCPlus4 !== 32'h0040_0008 || IFID_Valid !== 1'b1 || FetchCount !== 32'd2) begin
                errors++; $display("FAIL stall_hold%0d: pc %h ifid %h/%h/%b count %0d want 00400008 10000001/00400008/1 2",
                                   i, PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount);
            end
        end
        Stall = 1'b0;
        push_fetch(32'h0040_0008);
        tick();
        sb_pop(e, ok);
        checks++;
        if (!ok || IFID_Instruction !== e.instr || IFID_PCPlus4 !== e.pc4 || FetchCount !== 32'd3) begin
            errors++; $display("FAIL stall_release: got %h/%h count %0d want %h/%h 3",
                               IFID_Instruction, IFID_PCPlus4, FetchCount, e.instr, e.pc4);
        end
    endtask

    task automatic test_redirect_priority();
        exp_t e; bit ok;
        // All three redirects together from PC=0x0040000C: JR wins.
        BranchTaken = 1'b1; BranchTarget  = 32'h0040_0040;
        Jump        = 1'b1; JumpIndex     = 26'h010_0030;
        JumpReg     = 1'b1; JumpRegTarget = 32'h0040_0020;
        tick();
        idle_inputs();
        checks++;
        if (PC !== 32'h0040_0020 || IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0 ||
            IFID_PCPlus4 !== 32'h0 || FetchCount !== 32'd3) begin
            errors++; $display("FAIL prio_jr: pc %h ifid %h/%h/%b count %0d want 00400020 0/0/0 3",
                               PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount);
        end
        push_fetch(32'h0040_0020);
        tick();
        sb_pop(e, ok);
        checks++;
        if (!ok || IFID_Instruction !== e.instr || IFID_PCPlus4 !== e.pc4 || IFID_Valid !== 1'b1) begin
            errors++; $display("FAIL prio_jr_target: got %h/%h want %h/%h",
                               IFID_Instruction, IFID_PCPlus4, e.instr, e.pc4);
        end
        // Jump beats branch; target {0x0, 0x0100010, 00} = 0x00400040.
        BranchTaken = 1'b1; BranchTarget = 32'h0040_0080;
        Jump        = 1'b1; JumpIndex    = 26'h010_0010;
        tick();
        idle_inputs();
        checks++;
        if (PC !== 32'h0040_0040 || IFID_Valid !== 1'b0) begin
            errors++; $display("FAIL prio_j: pc %h valid %b want 00400040/0", PC, IFID_Valid);
        end
        push_fetch(32'h0040_0040);
        tick();
        sb_pop(e, ok);
        checks++;
        if (!ok || IFID_Instruction !== e.instr || IFID_PCPlus4 !== e.pc4) begin
            errors++; $display("FAIL prio_j_target: got %h/%h want %h/%h",
                               IFID_Instruction, IFID_PCPlus4, e.instr, e.pc4);
        end
        // Branch alone.
        BranchTaken = 1'b1; BranchTarget = 32'h0040_0010;
        tick();
        idle_inputs();
        checks++;
        if (PC !== 32'h0040_0010 || IFID_Valid !== 1'b0 || FetchCount !== 32'd5) begin
            errors++; $display("FAIL branch: pc %h valid %b count %0d want 00400010/0/5", PC, IFID_Valid, FetchCount);
        end
        push_fetch(32'h0040_0010);
        tick();
        sb_pop(e, ok);
        checks++;
        if (!ok || IFID_Instruction !== e.instr || IFID_PCPlus4 !== e.pc4) begin
            errors++; $display("FAIL branch_target: got %h/%h want %h/%h",
                               IFID_Instruction, IFID_PCPlus4, e.instr, e.pc4);
        end
    endtask

    task automatic test_jump_stall();
        exp_t e; bit ok;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push_fetch(RESET_PC + 32'(4 * k));
            tick();
            sb_pop(e, ok);
            checks++;
            if (!ok || IFID_Instruction !== e.instr || IFID_PCPlus4 !== e.pc4) begin
                errors++; $display("FAIL jump_pre%0d: got %h/%h want %h/%h",
                                   k, IFID_Instruction, IFID_PCPlus4, e.instr, e.pc4);
            end
        end
        Jump = 1'b1; JumpIndex = 26'h010_0010; Stall = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (PC !== 32'h0040_0040 || IFID_Valid !== 1'b0 || FetchCount !== 32'd4) begin
            errors++; $display("FAIL jump_stall: pc %h valid %b count %0d want 00400040/0/4",
                               PC, IFID_Valid, FetchCount);
        end
        push_fetch(32'h0040_0040);
        tick();
        sb_pop(e, ok);
        checks++;
        if (!ok || IFID_Instruction !== e.instr || IFID_PCPlus4 !== e.pc4 || IFID_Valid !== 1'b1) begin
            errors++; $display("FAIL jump_target: got %h/%h want %h/%h",
                               IFID_Instruction, IFID_PCPlus4, e.instr, e.pc4);
        end
    endtask

    task automatic test_halt();
        exp_t e; bit ok;
        do_reset();
        for (int k = 0; k < 32; k++) begin
            push_fetch(RESET_PC + 32'(4 * k));
            tick();
            sb_pop(e, ok);
            checks++;
            if (!ok || IFID_Instruction !== e.instr || IFID_PCPlus4 !== e.pc4 || IFID_Valid !== 1'b1) begin
                errors++; $display("FAIL halt_run%0d: got %h/%h/%b want %h/%h/1",
                                   k, IFID_Instruction, IFID_PCPlus4, IFID_Valid, e.instr, e.pc4);
            end
        end
        checks++;
        if (PC !== 32'h0040_0080 || FetchCount !== 32'd32 || Halted !== 1'b0) begin
            errors++; $display("FAIL halt_edge: pc %h count %0d halted %b want 00400080/32/0",
                               PC, FetchCount, Halted);
        end
        tick();
        checks++;
        if (Halted !== 1'b1 || IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0 ||
            IFID_PCPlus4 !== 32'h0 || PC !== 32'h0040_0080 || FetchCount !== 32'd32) begin
            errors++; $display("FAIL halt_enter: halted %b ifid %h/%h/%b pc %h count %0d",
                               Halted, IFID_Instruction, IFID_PCPlus4, IFID_Valid, PC, FetchCount);
        end
        for (int i = 0; i < 10; i++) begin
            Jump = 1'b1; JumpIndex = 26'h010_0000;
            JumpReg = i[0]; JumpRegTarget = RESET_PC;
            BranchTaken = 1'b1; BranchTarget = RESET_PC;
            Stall = i[1];
            tick();
            checks++;
            if (PC !== 32'h0040_0080 || Halted !== 1'b1 || IFID_Valid !== 1'b0 || FetchCount !== 32'd32) begin
                errors++; $display("FAIL halt_frozen%0d: pc %h halted %b valid %b count %0d",
                                   i, PC, Halted, IFID_Valid, FetchCount);
            end
        end
        idle_inputs();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (Halted !== 1'b0 || PC !== RESET_PC || FetchCount !== 32'h0) begin
            errors++; $display("FAIL halt_async_reset: halted %b pc %h count %0d want 0/%h/0",
                               Halted, PC, FetchCount, RESET_PC);
        end
        @(negedge clk);
        reset = 1'b0;
        push_fetch(RESET_PC);
        tick();
        sb_pop(e, ok);
        checks++;
        if (!ok || IFID_Instruction !== e.instr || IFID_PCPlus4 !== e.pc4 || IFID_Valid !== 1'b1) begin
            errors++; $display("FAIL halt_refetch: got %h/%h want %h/%h",
                               IFID_Instruction, IFID_PCPlus4, e.instr, e.pc4);
        end
    endtask

    task automatic test_illegal_target();
        // Misaligned JR target: redirect accepted, halt on the next edge.
        do_reset();
        JumpReg = 1'b1; JumpRegTarget = 32'h0040_0002;
        tick();
        idle_inputs();
        checks++;
        if (PC !== 32'h0040_0002 || IFID_Valid !== 1'b0 || Halted !== 1'b0) begin
            errors++; $display("FAIL misalign_redirect: pc %h valid %b halted %b", PC, IFID_Valid, Halted);
        end
        tick();
        checks++;
        if (Halted !== 1'b1 || PC !== 32'h0040_0002 || FetchCount !== 32'd0) begin
            errors++; $display("FAIL misalign_halt: halted %b pc %h count %0d", Halted, PC, FetchCount);
        end
        // Same with Stall held: no halt until Stall drops.
        do_reset();
        JumpReg = 1'b1; JumpRegTarget = 32'h0040_0002; Stall = 1'b1;
        tick();
        JumpReg = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (Halted !== 1'b0 || PC !== 32'h0040_0002) begin
                errors++; $display("FAIL misalign_stalled%0d: halted %b pc %h", i, Halted, PC);
            end
        end
        Stall = 1'b0;
        tick();
        checks++;
        if (Halted !== 1'b1 || IFID_Valid !== 1'b0) begin
            errors++; $display("FAIL misalign_release: halted %b valid %b want 1/0", Halted, IFID_Valid);
        end
        // Below the image base is also illegal.
        do_reset();
        BranchTaken = 1'b1; BranchTarget = 32'h003F_FFFC;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (Halted !== 1'b1 || PC !== 32'h003F_FFFC) begin
            errors++; $display("FAIL below_base: halted %b pc %h want 1/003ffffc", Halted, PC);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_priority();
        test_jump_stall();
        test_halt();
        test_illegal_target();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover: %0d entries want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
